// File: rtl/rgb_float_sequencer.sv
// RGB pixel to three IEEE-754 singles through one time-multiplexed converter.
// Optional RGB_FLOAT_NORM_EN scales each non-zero channel result by 1/256.

module int_to_float (
    input  logic [7:0]  i_val,
    output logic [31:0] o_flt
);

    logic [2:0]  w_msb;
    logic [22:0] w_mant;
    logic [7:0]  w_exp;

    always_comb begin
        w_msb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i_val[i]) w_msb = 3'(i);
        end
        // Leading one lands on bit 23 and falls off; lower bits left-align
        w_mant = {15'd0, i_val} << (5'd23 - {2'b00, w_msb});
`ifdef RGB_FLOAT_NORM_EN
        w_exp  = 8'd119 + {5'd0, w_msb};
`else
        w_exp  = 8'd127 + {5'd0, w_msb};
`endif
        o_flt  = (i_val == 8'd0) ? 32'd0 : {1'b0, w_exp, w_mant};
    end

endmodule

module rgb_float_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_rgb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic [31:0]      out_g,
    output logic [31:0]      out_b,
    output logic             busy,
    output logic [CNT_W-1:0] pix_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_R,
        S_CONV_G,
        S_CONV_B,
        S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [23:0]      r_pix;
    logic [31:0]      r_out_r;
    logic [31:0]      r_out_g;
    logic [31:0]      r_out_b;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       w_byte;
    logic [31:0]      w_flt;

    int_to_float u_conv (
        .i_val (w_byte),
        .o_flt (w_flt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_byte    = r_pix[23:16];
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_CONV_R;
            end
            S_CONV_R: begin
                w_byte = r_pix[23:16];
                w_next = S_CONV_G;
            end
            S_CONV_G: begin
                w_byte = r_pix[15:8];
                w_next = S_CONV_B;
            end
            S_CONV_B: begin
                w_byte = r_pix[7:0];
                w_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix   <= '0;
            r_out_r <= '0;
            r_out_g <= '0;
            r_out_b <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (in_valid) r_pix <= in_rgb;
                S_CONV_R: r_out_r <= w_flt;
                S_CONV_G: r_out_g <= w_flt;
                S_CONV_B: r_out_b <= w_flt;
                S_OUT:    if (out_ready) r_cnt <= r_cnt + 1'b1;
                default:  ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign out_r   = r_out_r;
    assign out_g   = r_out_g;
    assign out_b   = r_out_b;
    assign pix_cnt = r_cnt;

endmodule

// File: tb/tb_rgb_float_sequencer.sv
// Self-checking bench for rgb_float_sequencer (2-bit pixel counter build).
// Timing-based model of the handshakes plus literal conversion checks.

module tb_rgb_float_sequencer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [23:0]      in_rgb = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_r;
    logic [31:0]      out_g;
    logic [31:0]      out_b;
    logic             busy;
    logic [CNT_W-1:0] pix_cnt;

    int checks = 0;
    int errors = 0;

    rgb_float_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .busy      (busy),
        .pix_cnt   (pix_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference conversion from the numeric definition of a float
    function automatic logic [31:0] tofl(input int v);
        int p;
        int t;
        int frac;
        int mant;
        int ex;
        if (v == 0) return 32'd0;
        p = 0;
        t = v;
        while (t > 1) begin
            t = t / 2;
            p++;
        end
        frac = v - (1 << p);
        mant = frac * (1 << (23 - p));
`ifdef RGB_FLOAT_NORM_EN
        ex = 127 + p - 8;
`else
        ex = 127 + p;
`endif
        return {1'b0, 8'(ex), 23'(mant)};
    endfunction

    int   cyc = 0;
    logic rst_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    bit          m_live = 0;
    bit          m_have = 0;
    logic [23:0] m_pix;
    int          m_acc;
    int          m_cnt = 0;

    always @(negedge clk) begin
        bit ev;
        if (rst_q) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
            chk("rst_out_r", out_r, 32'd0);
            chk("rst_out_g", out_g, 32'd0);
            chk("rst_out_b", out_b, 32'd0);
            m_live = 1;
            m_have = 0;
            m_cnt  = 0;
        end else if (m_live) begin
            ev = m_have && (cyc >= m_acc + 4);
            chk("in_ready", 32'(in_ready), 32'(!m_have));
            chk("busy", 32'(busy), 32'(m_have));
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("pix_cnt", 32'(pix_cnt), 32'(m_cnt));
            if (ev) begin
                chk("out_r", out_r, tofl(int'(m_pix[23:16])));
                chk("out_g", out_g, tofl(int'(m_pix[15:8])));
                chk("out_b", out_b, tofl(int'(m_pix[7:0])));
            end
            if (!rst) begin
                if (ev && out_ready) begin
                    m_have = 0;
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                end else if (!m_have && in_valid) begin
                    m_have = 1;
                    m_pix  = in_rgb;
                    m_acc  = cyc;
                end
            end
        end
    end

    task automatic send(input logic [23:0] rgb);
        bit ok;
        ok = 0;
        @(posedge clk) #1;
        in_rgb   = rgb;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input int hold, input logic [31:0] er,
                        input logic [31:0] eg, input logic [31:0] eb,
                        input int ecnt);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        chk("recv_timeout", 32'(ok), 32'd1);
        repeat (hold) @(negedge clk);
        @(posedge clk) #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("lit_r", out_r, er);
        chk("lit_g", out_g, eg);
        chk("lit_b", out_b, eb);
        @(posedge clk) #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("lit_cnt", 32'(pix_cnt), 32'(ecnt));
        chk("lit_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] e_ff;
        logic [31:0] e_01;
        logic [31:0] e_80;
        logic [31:0] e_c8;
        logic [31:0] e_0a;
        logic [31:0] e_02;
        int          last;
        bit          ok;
`ifdef RGB_FLOAT_NORM_EN
        e_ff = 32'h3F7F0000;
        e_01 = 32'h3B800000;
        e_80 = 32'h3F000000;
        e_c8 = 32'h3F480000;
        e_0a = 32'h3D200000;
        e_02 = 32'h3C000000;
`else
        e_ff = 32'h437F0000;
        e_01 = 32'h3F800000;
        e_80 = 32'h43000000;
        e_c8 = 32'h43480000;
        e_0a = 32'h41200000;
        e_02 = 32'h40000000;
`endif
        chk("model_ff", tofl(255), e_ff);
        chk("model_01", tofl(1), e_01);
        chk("model_c8", tofl(200), e_c8);
        chk("model_00", tofl(0), 32'd0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(24'hFF0180);
        recv(0, e_ff, e_01, e_80, 1);
        send(24'h000000);
        recv(0, 32'd0, 32'd0, 32'd0, 2);
        send(24'hC80A02);
        recv(10, e_c8, e_0a, e_02, 3);
        send(24'h123456);
        recv(2, tofl(8'h12), tofl(8'h34), tofl(8'h56), 0);
        send(24'h01FE7F);
        recv(0, e_01, tofl(8'hFE), tofl(8'h7F), 1);

        // Streaming: in_valid held high, new pixel after each accept
        last = 0;
        @(posedge clk) #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_rgb = 24'(32'h10_20_30 + k * 32'h050709);
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1;
                    break;
                end
            end
            chk("stream_timeout", 32'(ok), 32'd1);
            if (k > 0) chk("stream_period", 32'(cyc - last), 32'd5);
            last = cyc;
            @(posedge clk) #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the middle of a conversion
        send(24'hABCDEF);
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_cnt", 32'(pix_cnt), 32'd0);
        send(24'hC80A02);
        recv(1, e_c8, e_0a, e_02, 1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_float_sequencer.md
Name: rgb_float_sequencer

Overview:
Accepts one 24-bit RGB pixel (three 8-bit unsigned channels) per valid/ready handshake. Converts the R, G and B channels one after another through a single shared 8-bit-unsigned to IEEE-754 single-precision converter instance (int_to_float), which is time-multiplexed. Presents the three 32-bit floats together on a valid/ready output. Sits between the pixel source and the float-domain colour pipeline, so one converter serves all three channels.

Parameters:
CNT_W, 16, width of the output-pixel counter pix_cnt

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  pixel on in_rgb is valid
in_ready  output  1  block can accept a pixel this cycle
in_rgb  input  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B, unsigned
out_valid  output  1  out_r/out_g/out_b hold a converted pixel
out_ready  input  1  downstream accepts the output this cycle
out_r  output  32  IEEE-754 single, red
out_g  output  32  IEEE-754 single, green
out_b  output  32  IEEE-754 single, blue
busy  output  1  high in any state other than IDLE
pix_cnt  output  CNT_W  count of completed output handshakes

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_r/out_g/out_b=0, pix_cnt=0, internal pixel register=0.
- FSM states: IDLE, CONV_R, CONV_G, CONV_B, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_rgb into the pixel register and go to CONV_R.
- CONV_R / CONV_G / CONV_B:
  - Converter input mux selects the captured R, G or B byte respectively.
  - The converter output is registered into out_r / out_g / out_b at the end of that cycle.
  - Transitions: CONV_R->CONV_G->CONV_B->OUT, unconditionally.
- OUT:
  - out_valid=1. out_r/out_g/out_b are held stable while out_valid=1 and out_ready=0.
  - On out_ready: pix_cnt increments, then go to IDLE.
- in_ready is 0 in every state except IDLE. An in_valid arriving while busy is ignored, not captured; the source must hold it.
- Latency: input handshake at cycle N -> out_valid=1 at cycle N+4. Minimum of 5 cycles per pixel (the IDLE cycle is included).
- Converter is purely combinational, giving one conversion per cycle.
- Zero channel converts to 0x00000000. Non-zero v converts to exponent (floor(log2 v)+127) with the bits below the MSB left-aligned in the mantissa; conversion is exact and needs no rounding.
- pix_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- out_ready asserted outside OUT has no effect.
- rst asserted mid-conversion or in OUT:
  - The pixel in flight is discarded and out_valid drops the next cycle.
  - All registers return to reset values, including pix_cnt.
- Output registers update only in the CONV states. Between pixels they keep the last values, but are meaningful only while out_valid=1.

Optional Feature:
Macro RGB_FLOAT_NORM_EN.
- Defined: each non-zero channel result has 8 subtracted from its exponent field before it is registered. This gives v/256 in [0, 0.99609375]; zero stays 0x00000000. Latency and handshake are unchanged.
- Undefined: raw value v is produced, in the range 0.0 to 255.0.

Test Plan:
- Reset, then in_rgb=0xFF0180 with in_valid=1 and out_ready=1 -> out_valid 4 cycles after the handshake.
  - Without macro: out_r=0x437F0000, out_g=0x3F800000, out_b=0x43000000, pix_cnt=1.
  - With RGB_FLOAT_NORM_EN: out_r=0x3F7F0000, out_g=0x3B800000, out_b=0x3F000000.
- in_rgb=0x000000 -> all outputs 0x00000000; in_rgb=0xC80A02 -> 0x43480000, 0x41200000, 0x40000000.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid and outputs stable, in_ready=0, pix_cnt unchanged. Release -> pix_cnt increments once, back to IDLE.
- Drive in_valid=1 continuously with a new pixel each accepted cycle -> in_ready pulses exactly once every 5 cycles, and every pixel appears in order with no drops.
- Assert rst during CONV_G -> the next cycle shows state IDLE, out_valid=0, pix_cnt=0, in_ready=1. A subsequent pixel converts correctly.
- CNT_W=2: complete 5 pixels -> pix_cnt reads 1, 2, 3, 0, 1.
